dac_update_sequencer: RTL

// Sequences one synchronous DAC update across the per-DAC FIFO/SPI chains.
// On a request from the control module it starts the selected SPI transmitters together
// and waits for every shift to finish. It then pulses LDAC on the selected DACs and waits
// for their BUSY to clear. Sits between control and the spi_transmitter/DAC pins; owns
// spi_start_transmit and dac_ldac_n.

---
 rtl/dac_update_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dac_update_sequencer.sv
// Sequences one synchronous DAC update: start selected SPI shifts, wait, pulse LDAC, wait for BUSY.
// Latency: first start strobe 1 cycle after an accepted request; outputs decode from registered state.
// Backpressure: none; a request while busy is dropped (req_dropped pulse), never queued.
module dac_update_sequencer #(
  parameter int DACN     = 2,
  parameter int LDAC_CYC = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            update_req,
  input  logic [DACN-1:0] update_mask,
  input  logic [DACN-1:0] fifo_empty,
  input  logic [DACN-1:0] spi_busy,
  input  logic [DACN-1:0] dac_busy_n,
  output logic [DACN-1:0] spi_start_transmit,
  output logic [DACN-1:0] dac_ldac_n,
  output logic            seq_busy,
  output logic            seq_done,
  output logic            seq_error,
  output logic [DACN-1:0] error_mask,
  output logic            req_dropped
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT);
  localparam logic [CW-1:0] LDAC_LAST   = CW'(LDAC_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SETTLE,
    S_WAIT_SPI,
    S_LDAC,
    S_GUARD,
    S_WAIT_DAC,
    S_DONE,
    S_ABORT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DACN-1:0] active_q, active_d;
  logic [DACN-1:0] error_mask_q, error_mask_d;
  logic [DACN-1:0] busy_meta, busy_sync;
  logic [DACN-1:0] req_active;
  logic [DACN-1:0] spi_pending;
  logic [DACN-1:0] dac_pending;

  // BUSY pins are asynchronous to clock: two-flop synchronizer, idle level is 1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_meta <= '1;
      busy_sync <= '1;
    end else begin
      busy_meta <= dac_busy_n;
      busy_sync <= busy_meta;
    end
  end

  assign req_active  = update_mask & ~fifo_empty;
  assign spi_pending = spi_busy & active_q;
  assign dac_pending = ~busy_sync & active_q;

  // State, phase/timeout counter, latched channel set and abort mask
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      active_q     <= '0;
      error_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      error_mask_q <= error_mask_d;
    end
  end

  // Next-state and Moore output decode; counter restarts on every state change
  always_comb begin
    state_d            = state_q;
    active_d           = active_q;
    error_mask_d       = error_mask_q;
    spi_start_transmit = '0;
    dac_ldac_n         = '1;
    seq_done           = 1'b0;
    seq_error          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (update_req) begin
          active_d     = req_active;
          error_mask_d = '0;
          state_d      = (|req_active) ? S_START : S_DONE;
        end
      end
      S_START: begin
        spi_start_transmit = active_q;
        state_d            = S_SETTLE;
      end
      S_SETTLE: begin
        // give the transmitters time to raise busy before it is trusted
        if (cnt_q == SETTLE_LAST) state_d = S_WAIT_SPI;
      end
      S_WAIT_SPI: begin
        if (spi_pending == '0) begin
          state_d = S_LDAC;
        end else if (cnt_q == TMO_LAST) begin
          error_mask_d = spi_pending;
          state_d      = S_ABORT;
        end
      end
      S_LDAC: begin
        dac_ldac_n = ~active_q;
        if (cnt_q == LDAC_LAST) state_d = S_GUARD;
      end
      S_GUARD: begin
        // synchronizer delay plus DAC BUSY assertion time
        if (cnt_q == GUARD_LAST) state_d = S_WAIT_DAC;
      end
      S_WAIT_DAC: begin
        if (dac_pending == '0) begin
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          error_mask_d = dac_pending;
          state_d      = S_ABORT;
        end
      end
      S_DONE: begin
        seq_done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ABORT: begin
        seq_error = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q || state_q == S_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign seq_busy    = (state_q != S_IDLE);
  assign req_dropped = update_req & seq_busy;
  assign error_mask  = error_mask_q;

endmodule
